// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath mux/ALU selects and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decode. Only FETCH looks at mem_ready and
// only DECODE looks at opcode, so the outputs are Moore except for those two.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      cur,
    input  logic        mem_ready,
    input  logic [5:0]  opcode,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (cur)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                // IR and PC only update once the instruction word has arrived
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_legal_op(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: state register and next-state logic here,
// control decode in mips_ctrl_decode.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t cur, nxt;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:     nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = S_EXECUTE;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDI_EXEC;
                    default:      nxt = S_FETCH;
                endcase
            end
            // opcode is still the IR field here; anything else abandons safely
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      nxt = S_MEM_READ;
                else if (opcode == OP_SW) nxt = S_MEM_WRITE;
                else                      nxt = S_FETCH;
            end
            S_MEM_READ:  nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   nxt = S_ALU_WB;
            S_ADDI_EXEC: nxt = S_ADDI_WB;
            default:     nxt = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .cur       (cur),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scenario bench for multicycle_control_fsm: each cycle's stimulus and
// expected state/control word are queued, then replayed and compared.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mr;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [16:0] c;
    } item_t;

    item_t sb[$];
    item_t it;

    logic [16:0] obs;
    assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b,
                  alu_op, pc_source, illegal_op};

    always #5 clk = ~clk;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // Expected control word per state, written from the state/output table.
    function automatic logic [16:0] ctl(input int st, input logic mr, input logic ill);
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rw = 0, rd = 0, sa = 0;
        logic [1:0] sb2 = 0, ao = 0, ps = 0;
        case (st)
            0:  begin mrd = 1; sb2 = 2'b01; irw = mr; pw = mr; end
            1:  sb2 = 2'b11;
            2:  begin sa = 1; sb2 = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb2 = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rw, rd, sa, sb2, ao, ps, (st == 1) && ill};
    endfunction

    task automatic push(input logic mr, input logic [5:0] op, input int st, input logic ill);
        item_t x;
        x.mr = mr; x.op = op; x.st = 4'(st); x.c = ctl(st, mr, ill);
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
        #2;
        @(negedge clk);
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++;
        if (obs !== ctl(0, 1'b1, 1'b0)) begin errors++; $display("FAIL reset_ctl_ready got %h want %h", obs, ctl(0, 1'b1, 1'b0)); end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== ctl(0, 1'b0, 1'b0)) begin errors++; $display("FAIL reset_ctl_idle got %h want %h", obs, ctl(0, 1'b0, 1'b0)); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_stall();
        for (int i = 0; i < 5; i++) push(1'b0, 6'h23, 0, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr; opcode = it.op;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin errors++; $display("FAIL fetch_stall state got %0d want %0d", state, it.st); end
            checks++;
            if (obs !== it.c) begin errors++; $display("FAIL fetch_stall ctl got %h want %h", obs, it.c); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        // opcode disturbed after MEM_ADDR must not matter
        push(1'b1, 6'h23, 0, 1'b0);
        push(1'b0, 6'h23, 1, 1'b0);
        push(1'b0, 6'h23, 2, 1'b0);
        push(1'b1, 6'h00, 3, 1'b0);
        push(1'b1, 6'h3F, 4, 1'b0);
        push(1'b0, 6'h3F, 0, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr; opcode = it.op;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin errors++; $display("FAIL lw state got %0d want %0d", state, it.st); end
            checks++;
            if (obs !== it.c) begin errors++; $display("FAIL lw ctl got %h want %h", obs, it.c); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        push(1'b1, 6'h2B, 0, 1'b0);
        push(1'b0, 6'h2B, 1, 1'b0);
        push(1'b0, 6'h2B, 2, 1'b0);
        for (int i = 0; i < 3; i++) push(1'b0, 6'h2B, 5, 1'b0);
        push(1'b1, 6'h2B, 5, 1'b0);
        push(1'b0, 6'h2B, 0, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr; opcode = it.op;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin errors++; $display("FAIL sw state got %0d want %0d", state, it.st); end
            checks++;
            if (obs !== it.c) begin errors++; $display("FAIL sw ctl got %h want %h", obs, it.c); end
            checks++;
            if (mem_read && mem_write) begin errors++; $display("FAIL sw rd_wr_excl got 1 want 0"); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        push(1'b1, 6'h04, 0, 1'b0);
        push(1'b0, 6'h04, 1, 1'b0);
        push(1'b0, 6'h04, 8, 1'b0);
        push(1'b1, 6'h02, 0, 1'b0);
        push(1'b0, 6'h02, 1, 1'b0);
        push(1'b0, 6'h02, 9, 1'b0);
        push(1'b0, 6'h02, 0, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr; opcode = it.op;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin errors++; $display("FAIL beq_j state got %0d want %0d", state, it.st); end
            checks++;
            if (obs !== it.c) begin errors++; $display("FAIL beq_j ctl got %h want %h", obs, it.c); end
            checks++;
            if (pc_write && pc_write_cond) begin errors++; $display("FAIL beq_j pc_excl got 1 want 0"); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_addi();
        push(1'b1, 6'h00, 0, 1'b0);
        push(1'b0, 6'h00, 1, 1'b0);
        push(1'b0, 6'h00, 6, 1'b0);
        push(1'b0, 6'h00, 7, 1'b0);
        push(1'b1, 6'h08, 0, 1'b0);
        push(1'b0, 6'h08, 1, 1'b0);
        push(1'b0, 6'h08, 10, 1'b0);
        push(1'b0, 6'h08, 11, 1'b0);
        push(1'b0, 6'h08, 0, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr; opcode = it.op;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin errors++; $display("FAIL rtype_addi state got %0d want %0d", state, it.st); end
            checks++;
            if (obs !== it.c) begin errors++; $display("FAIL rtype_addi ctl got %h want %h", obs, it.c); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        push(1'b1, 6'h3F, 0, 1'b0);
        push(1'b0, 6'h3F, 1, 1'b1);
        push(1'b0, 6'h3F, 0, 1'b0);
        push(1'b0, 6'h3F, 0, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr; opcode = it.op;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin errors++; $display("FAIL illegal state got %0d want %0d", state, it.st); end
            checks++;
            if (obs !== it.c) begin errors++; $display("FAIL illegal ctl got %h want %h", obs, it.c); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_op();
        push(1'b1, 6'h00, 0, 1'b0);
        push(1'b0, 6'h00, 1, 1'b0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr; opcode = it.op;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin errors++; $display("FAIL reset_mid state got %0d want %0d", state, it.st); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (state !== 4'd6) begin errors++; $display("FAIL reset_mid exec got %0d want 6", state); end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_mid async got %0d want 0", state); end
        checks++;
        if (obs !== ctl(0, 1'b0, 1'b0)) begin errors++; $display("FAIL reset_mid ctl got %h want %h", obs, ctl(0, 1'b0, 1'b0)); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b1;
            checks++;
            if (state !== 4'd0 || reg_write !== 1'b0) begin
                errors++; $display("FAIL reset_mid after got st=%0d rw=%b want st=0 rw=0", state, reg_write);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_lw();
        test_sw_stall();
        test_branch_jump();
        test_rtype_addi();
        test_illegal();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 4, the width of the state debug output.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 6, the instruction-register opcode field [31:26].
REQ-005 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-006 SHALL have ports pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst and alu_src_a, each output, 1, enable/select to the datapath.
REQ-007 SHALL have ports alu_src_b, alu_op and pc_source, each output, 2, datapath mux/ALU controls.
REQ-008 SHALL have port illegal_op, output, 1, one-cycle pulse on an unsupported opcode.
REQ-009 SHALL have port state, output, STATE_W, current state encoding for debug.

Function
REQ-010 SHALL implement states with fixed encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
REQ-011 SHALL transition as follows: FETCH->DECODE only when mem_ready=1, otherwise it SHALL stay in FETCH.
REQ-012 SHALL transition DECODE on opcode: 0x23/0x2B->MEM_ADDR, 0x00->EXECUTE, 0x04->BRANCH, 0x02->JUMP, 0x08->ADDI_EXEC, any other->FETCH with illegal_op=1 for that one cycle.
REQ-013 SHALL transition MEM_ADDR->MEM_READ for 0x23 and ->MEM_WRITE for 0x2B.
REQ-014 SHALL transition MEM_READ->MEM_WB and MEM_WRITE->FETCH only when mem_ready=1; it SHALL hold the state otherwise.
REQ-015 SHALL transition MEM_WB, ALU_WB, BRANCH, JUMP and ADDI_WB to FETCH, EXECUTE to ALU_WB, and ADDI_EXEC to ADDI_WB, each unconditionally.
REQ-016 SHALL drive FETCH outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, and ir_write=pc_write=mem_ready.
REQ-017 SHALL drive DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch-target precompute).
REQ-018 SHALL drive MEM_ADDR outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-019 SHALL drive MEM_READ outputs: mem_read=1, iord=1.
REQ-020 SHALL drive MEM_WRITE outputs: mem_write=1, iord=1.
REQ-021 SHALL drive MEM_WB outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-022 SHALL drive EXECUTE outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-023 SHALL drive ALU_WB outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-024 SHALL drive BRANCH outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
REQ-025 SHALL drive JUMP outputs: pc_write=1, pc_source=10.
REQ-026 SHALL drive ADDI_EXEC outputs: alu_src_a=1, alu_src_b=10, alu_op=00; and ADDI_WB outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-027 SHALL drive every control not listed for a state to 0.
REQ-028 SHALL derive all outputs combinationally from state, plus mem_ready in FETCH and opcode in DECODE (illegal_op only).
REQ-029 SHALL, in any unused encoding 12-15, drive all controls to 0 and go to FETCH next cycle.
REQ-030 SHALL treat opcode as sampled from the instruction register; opcode changes outside DECODE/MEM_ADDR SHALL have no effect.
REQ-031 SHALL assert mem_read and mem_write never in the same cycle, nor pc_write and pc_write_cond.

Reset
REQ-032 SHALL force state=FETCH asynchronously when reset=0, with outputs being FETCH outputs (mem_read=1, alu_src_b=01, all others 0 except ir_write/pc_write=mem_ready).
REQ-033 SHALL, on reset assertion mid-instruction, abandon the instruction with no further write enable asserted after reset release except by FETCH.

Structure
REQ-034 SHALL place the state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI) and alu_op/alu_src_b/pc_source encodings in shared package mips_ctrl_pkg.
REQ-035 SHALL use one sub-module, mips_ctrl_decode, holding the combinational state-to-control decode; the next-state register SHALL remain in the top module.

Verification
REQ-036 SHALL verify LW: reset release, mem_ready=1, opcode=0x23 -> states 0,1,2,3,4,0, with reg_write=1 and mem_to_reg=1 only in state 4.
REQ-037 SHALL verify SW with stall: opcode=0x2B, mem_ready=0 for 3 cycles in MEM_WRITE -> mem_write=1 held 4 cycles, then FETCH.
REQ-038 SHALL verify BEQ and J: opcode=0x04 -> pc_write_cond=1, pc_source=01 in state 8; opcode=0x02 -> pc_write=1, pc_source=10 in state 9; both take 3 cycles total.
REQ-039 SHALL verify illegal opcode: opcode=0x3F -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no reg_write/mem_write asserted.
REQ-040 SHALL verify reset mid-operation: reset=0 asserted during EXECUTE (opcode=0x00) -> state=0 immediately, and reg_write never asserted.
REQ-041 SHALL verify FETCH stall: mem_ready=0 for 5 cycles -> state stays 0 with ir_write=pc_write=0 throughout.
